// File: rtl/gen_gamma_pkg.sv
// Shared types and sizes for the gamma decoder.
// Width defaults, FSM state encoding and counter sizing.
package gen_gamma_pkg;

   localparam int DW_DEF  = 8;
   localparam int MDW_DEF = DW_DEF + 1;
   localparam int CNT_W   = $clog2(DW_DEF + 1);

   typedef enum logic [1:0] {
      NOKEY,
      IDLE,
      SUB,
      HOLD
   } state_t;

endpackage

// File: rtl/gen_gamma_bit_sub.sv
// One-bit serial full subtractor.
// Borrow is held in a register between bit slices.
module gen_gamma_bit_sub (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   input  logic a,
   input  logic b,
   output logic d
);

   logic borrow_q;
   logic borrow_d;

   assign d = a ^ b ^ borrow_q;

   always_comb begin
      borrow_d = borrow_q;
      if (clr)
         borrow_d = 1'b0;
      else if (en)
         borrow_d = (~a & b) | (~(a ^ b) & borrow_q);
   end

   always_ff @(posedge clk) begin
      if (rst)
         borrow_q <= 1'b0;
      else
         borrow_q <= borrow_d;
   end

endmodule

// File: rtl/gen_gamma_decoder.sv
// Gamma decoder: recovers id = md - key, one bit per clock, LSB first.
// Result is flagged when md < key or the difference exceeds DW bits.
module gen_gamma_decoder
   import gen_gamma_pkg::*;
#(
   parameter int DW = DW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          key_ld_i,
   input  logic [DW-1:0] key_i,
   output logic          key_vld_o,
   input  logic          md_valid_i,
   output logic          md_ready_o,
   input  logic [DW:0]   md_i,
   output logic          od_valid_o,
   input  logic          od_ready_i,
   output logic [DW-1:0] od_o,
   output logic          od_err_o
);

   localparam int MDW = DW + 1;
   localparam int CW  = $clog2(DW + 1);

   state_t           state_q, state_d;
   logic [DW-1:0]    key_q;
   logic             key_vld_q;
   logic [MDW-1:0]   a_q, a_d;
   logic [MDW-1:0]   b_q, b_d;
   logic [MDW-1:0]   res_q, res_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             sub_clr;
   logic             sub_en;
   logic             sub_d;
   logic             err;

   gen_gamma_bit_sub u_sub (
      .clk (clk),
      .rst (rst),
      .clr (sub_clr),
      .en  (sub_en),
      .a   (a_q[0]),
      .b   (b_q[0]),
      .d   (sub_d)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      cnt_d   = cnt_q;
      sub_clr = 1'b0;
      sub_en  = 1'b0;
      unique case (state_q)
         NOKEY: begin
            if (key_ld_i)
               state_d = IDLE;
         end
         IDLE: begin
            if (md_valid_i) begin
               a_d     = md_i;
               b_d     = {1'b0, key_q};
               cnt_d   = '0;
               sub_clr = 1'b1;
               state_d = SUB;
            end
         end
         SUB: begin
            sub_en = 1'b1;
            a_d    = {1'b0, a_q[MDW-1:1]};
            b_d    = {1'b0, b_q[MDW-1:1]};
            res_d  = {sub_d, res_q[MDW-1:1]};
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == CW'(DW))
               state_d = HOLD;
         end
         HOLD: begin
            if (od_ready_i)
               state_d = IDLE;
         end
         default: state_d = NOKEY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= NOKEY;
         key_q     <= '0;
         key_vld_q <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         res_q     <= '0;
         cnt_q     <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
         if (key_ld_i) begin
            key_q     <= key_i;
            key_vld_q <= 1'b1;
         end
      end
   end

   // Operands are fully shifted out in HOLD, so the subtractor
   // output there is exactly the final borrow.
   assign err = sub_d | res_q[DW];

   assign key_vld_o  = key_vld_q;
   assign md_ready_o = (state_q == IDLE);
   assign od_valid_o = (state_q == HOLD);
   assign od_err_o   = od_valid_o & err;
   assign od_o       = (od_valid_o && !err) ? res_q[DW-1:0] : '0;

endmodule

// File: tb/tb_gen_gamma_decoder.sv
// Self-checking bench for gen_gamma_decoder.
// Directed vectors plus a cycle-level reference model.
module tb_gen_gamma_decoder;

   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          key_ld_i = 1'b0;
   logic [DW-1:0] key_i = '0;
   logic          key_vld_o;
   logic          md_valid_i = 1'b0;
   logic          md_ready_o;
   logic [DW:0]   md_i = '0;
   logic          od_valid_o;
   logic          od_ready_i = 1'b1;
   logic [DW-1:0] od_o;
   logic          od_err_o;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   int t_acc = 0;

   gen_gamma_decoder #(.DW(DW)) dut (
      .clk        (clk),
      .rst        (rst),
      .key_ld_i   (key_ld_i),
      .key_i      (key_i),
      .key_vld_o  (key_vld_o),
      .md_valid_i (md_valid_i),
      .md_ready_o (md_ready_o),
      .md_i       (md_i),
      .od_valid_o (od_valid_o),
      .od_ready_i (od_ready_i),
      .od_o       (od_o),
      .od_err_o   (od_err_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   // Reference model: key knowledge, work countdown, held result.
   bit          m_keyv = 0;
   logic [7:0]  m_key  = '0;
   int          m_left = 0;
   bit          m_hold = 0;
   logic [7:0]  m_od   = '0;
   bit          m_err  = 0;

   always @(negedge clk) begin
      bit exp_rdy;
      int diff;
      exp_rdy = m_keyv && (m_left == 0) && !m_hold;
      chk("m_key_vld", key_vld_o, m_keyv);
      chk("m_md_ready", md_ready_o, exp_rdy);
      chk("m_od_valid", od_valid_o, m_hold);
      chk("m_od", od_o, m_hold ? m_od : 8'h00);
      chk("m_od_err", od_err_o, m_hold ? m_err : 1'b0);
      if (rst) begin
         m_keyv = 0;
         m_key  = '0;
         m_left = 0;
         m_hold = 0;
      end else begin
         if (exp_rdy && md_valid_i) begin
            diff   = int'(md_i) - int'(m_key);
            m_err  = (diff < 0) || (diff > 255);
            m_od   = m_err ? 8'h00 : 8'(diff);
            m_left = DW + 1;
         end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_hold = 1;
         end else if (m_hold && od_ready_i) begin
            m_hold = 0;
         end
         if (key_ld_i) begin
            m_key  = key_i;
            m_keyv = 1;
         end
      end
   end

   task automatic load_key(input logic [7:0] k);
      key_ld_i = 1'b1;
      key_i    = k;
      @(posedge clk); #1;
      key_ld_i = 1'b0;
   endtask

   task automatic send(input logic [8:0] md);
      bit ok;
      ok = 0;
      md_i       = md;
      md_valid_i = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (md_ready_o) begin
            ok = 1;
            break;
         end
      end
      chk("accept_timeout", ok, 1'b1);
      t_acc = cyc;
      @(posedge clk); #1;
      md_valid_i = 1'b0;
   endtask

   task automatic expect_out(input string nm, input logic [7:0] od,
                             input logic err);
      bit ok;
      ok = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (od_valid_o) begin
            ok = 1;
            break;
         end
      end
      chk({nm, "_valid"}, ok, 1'b1);
      chk({nm, "_lat"}, cyc - t_acc, DW + 2);
      chk({nm, "_od"}, od_o, od);
      chk({nm, "_err"}, od_err_o, err);
      @(posedge clk); #1;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_key_vld", key_vld_o, 1'b0);
      chk("rst_md_ready", md_ready_o, 1'b0);
      chk("rst_od_valid", od_valid_o, 1'b0);

      // No key: offered word must wait.
      md_i = 9'h050;
      md_valid_i = 1'b1;
      repeat (20) @(negedge clk);
      chk("nokey_ready", md_ready_o, 1'b0);
      @(posedge clk); #1;
      load_key(8'h10);
      @(negedge clk);
      chk("key_ready", md_ready_o, 1'b1);
      t_acc = cyc;
      @(posedge clk); #1;
      md_valid_i = 1'b0;
      expect_out("nokey_word", 8'h40, 1'b0);

      // Nominal and error words.
      load_key(8'hA5);
      send(9'h1A4); expect_out("nom_ff", 8'hFF, 1'b0);
      send(9'h0A5); expect_out("nom_00", 8'h00, 1'b0);
      send(9'h0A4); expect_out("err_lo", 8'h00, 1'b1);
      send(9'h1A5); expect_out("err_hi", 8'h00, 1'b1);
      send(9'h1FF); expect_out("err_max", 8'h00, 1'b1);
      send(9'h000); expect_out("err_zero", 8'h00, 1'b1);

      // Backpressure.
      od_ready_i = 1'b0;
      send(9'h1A0);
      expect_out("bp", 8'hFB, 1'b0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("bp_od", od_o, 8'hFB);
         chk("bp_err", od_err_o, 1'b0);
         chk("bp_rdy", md_ready_o, 1'b0);
         @(posedge clk); #1;
      end
      od_ready_i = 1'b1;
      @(negedge clk);
      chk("bp_xfer_valid", od_valid_o, 1'b1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_after_rdy", md_ready_o, 1'b1);
      chk("bp_after_od", od_o, 8'h00);

      // Key change while a word is in flight.
      load_key(8'h01);
      send(9'h003);
      load_key(8'h02);
      expect_out("kchg_a", 8'h02, 1'b0);
      send(9'h003); expect_out("kchg_b", 8'h01, 1'b0);

      // Same-cycle key load and accept: old key applies.
      key_ld_i = 1'b1;
      key_i    = 8'h04;
      send(9'h005);
      key_ld_i = 1'b0;
      expect_out("kcoll_a", 8'h03, 1'b0);
      send(9'h005); expect_out("kcoll_b", 8'h01, 1'b0);

      // Reset in the middle of a subtraction.
      send(9'h0A0);
      repeat (3) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      md_valid_i = 1'b1;
      md_i = 9'h030;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         chk("mrst_valid", od_valid_o, 1'b0);
         chk("mrst_kvld", key_vld_o, 1'b0);
         chk("mrst_rdy", md_ready_o, 1'b0);
      end
      @(posedge clk); #1;
      md_valid_i = 1'b0;
      load_key(8'h20);
      send(9'h030); expect_out("mrst_new", 8'h10, 1'b0);

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/gen_gamma_decoder.md
Name: gen_gamma_decoder

Overview:
- Receiver-side counterpart of the gamma coder.
- The coder produces a 9-bit mixed word md = id + nk from an 8-bit input word and an 8-bit noise key. This block is given the same key and recovers id = md - nk.
- Subtraction is bit-serial, LSB first, one bit per clock, to keep area at gate-level scale.
- Valid/ready handshakes are used on the input and output sides. Out-of-range mixed words are flagged.

Parameters:
- DW, 8, data/key width; the mixed word is DW+1 bits wide.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset: synchronous, active-high.
- key_ld_i  in  1  load noise key this cycle.
- key_i  in  DW  noise key value.
- key_vld_o  out  1  a key has been loaded since reset.
- md_valid_i  in  1  mixed word offered.
- md_ready_o  out  1  block can accept a mixed word.
- md_i  in  DW+1  mixed word.
- od_valid_o  out  1  decoded word available.
- od_ready_i  in  1  consumer accepts the decoded word.
- od_o  out  DW  decoded word.
- od_err_o  out  1  mixed word was inconsistent with the key; qualified by od_valid_o.

Behaviour:
- Reset: state NOKEY; key, shift and result registers = 0; key_vld_o=0, md_ready_o=0, od_valid_o=0, od_o=0, od_err_o=0. Reset asserted mid-transaction discards the transaction at the next edge.
- Key register: when key_ld_i=1, it loads key_i in any state at the next edge. key_vld_o goes to 1 the cycle after the first load and stays 1 until rst.
- FSM states:
  - NOKEY -> IDLE: the edge after key_ld_i.
  - IDLE -> SUB: on md_valid_i & md_ready_o.
  - SUB -> HOLD: after DW+1 cycles.
  - HOLD -> IDLE: on od_ready_i.
- md_ready_o = 1 only in IDLE (registered state decode, no combinational path from od_ready_i).
- Accept cycle t (IDLE):
  - A <= md_i; B <= {1'b0, key}; borrow <= 0; cnt <= 0.
  - The key value used is the register contents before any same-cycle key_ld_i, so the old key wins.
- SUB, cycles t+1 .. t+DW+1:
  - d = A[0]^B[0]^borrow.
  - borrow <= (~A[0]&B[0]) | (~(A[0]^B[0])&borrow).
  - A and B shift right; d shifts into the result MSB; cnt increments.
  - Leave SUB when cnt = DW.
- key_ld_i during SUB or HOLD updates the key register only and does not affect the in-flight word.
- HOLD, from t+DW+2:
  - od_valid_o = 1.
  - err = final borrow (md < key) OR result[DW] (difference > 2^DW-1).
  - od_o = err ? 0 : result[DW-1:0]; od_err_o = err.
  - od_o and od_err_o are held stable while od_valid_o=1 and od_ready_i=0.
  - Transfer happens on the edge with od_valid_o & od_ready_i; the next cycle is IDLE with od_valid_o=0, and od_o and od_err_o return to 0.
- Latency and throughput:
  - Accept to od_valid_o is DW+2 cycles (10 for DW=8).
  - Minimum period is DW+3 cycles per word when od_ready_i is held high.
- md_valid_i outside IDLE is ignored; the producer must hold it until accepted.
- All arithmetic is unsigned, in DW+1 bits. No wrap-around result is ever presented without od_err_o=1.

Decomposition:
- Package gen_gamma_pkg:
  - DW default and MDW = DW+1.
  - FSM state enum {NOKEY, IDLE, SUB, HOLD}.
  - Counter width $clog2(DW+1).
- Sub-module gen_gamma_bit_sub:
  - One-bit full subtractor with registered borrow.
  - Ports: clk, rst, clr, en, a, b, d.
  - Instantiated once by the decoder.

Test Plan:
- No key: after rst, md_valid_i=1 with md_i=0x050 -> md_ready_o stays 0 for 20 cycles and od_valid_o=0. Then key_ld_i with key 0x10 -> md_ready_o=1 on the following cycle.
- Nominal: key 0xA5, md 0x1A4 accepted at t -> od_valid_o rises at t+10 with od_o=0xFF, od_err_o=0. Then md 0x0A5 -> od_o=0x00, err 0.
- Errors, key 0xA5:
  - md 0x0A4 -> od_err_o=1, od_o=0x00.
  - md 0x1A5 (difference 0x100) -> od_err_o=1, od_o=0x00.
- Backpressure: od_ready_i low for 5 cycles after od_valid_o -> od_o and od_err_o stable, md_ready_o=0 throughout. Transfer on the first high cycle; md_ready_o=1 on the next cycle.
- Key change mid-flight:
  - key 0x01 loaded, md 0x003 accepted, key_ld_i with key 0x02 during SUB -> od_o=0x02.
  - Next word md 0x003 -> od_o=0x01.
  - Same-cycle key_ld_i with accept -> old key used.
- Reset mid-SUB: rst asserted at t+4 for 1 cycle -> od_valid_o never rises, key_vld_o=0, md_ready_o=0 until a new key_ld_i.
